// File: rtl/exu_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage M-extension sequencer.
//   DATA_WIDTH : default operand/result width
//   md_op_e    : funct3 encodings of the RV32M operations
//   md_state_e : sequencer FSM states
package exu_muldiv_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/exu_muldiv_ctrl_iter_core.sv
// Iterative datapath shared by the shift-add multiplier and restoring divider.
// Operates on unsigned magnitudes only; sign handling lives in the controller.
//   clk, rst_n     : clock, synchronous active-low reset
//   load           : capture a (into lo) and b, clear hi
//   step           : perform one iteration
//   is_div         : select divide (1) or multiply (0) iteration
//   a, b           : operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   hi_nxt, lo_nxt : value hi/lo take on the next step
//                    (mul: product {hi,lo}; div: hi=remainder, lo=quotient)
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    always_comb begin
        sum    = {1'b0, hi_q} + {1'b0, b_q};
        rem_sh = {hi_q, lo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (is_div) begin
            // Bit XLEN of diff is the borrow: set means the trial subtract failed.
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = rem_sh[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_nxt, lo_nxt} = {sum, lo_q[XLEN-1:1]};
        end else begin
            {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else if (load) begin
            hi_q <= '0;
            lo_q <= a;
            b_q  <= b;
        end else if (step) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

endmodule

// File: rtl/exu_muldiv_ctrl.sv
// Multi-cycle RV32M sequencer beside the EX-stage ALU.
//   clk, rst_n     : clock, synchronous active-low reset
//   ex_valid       : EX holds a valid instruction
//   ex_muldiv_en   : instruction is an M-extension op
//   ex_muldiv_op   : funct3 (MUL..REMU)
//   ex_rs1_data    : operand a
//   ex_rs2_data    : operand b
//   ex_flush       : abort any op, back to idle
//   ex_advance     : EX->MEM capture this cycle (releases a finished result)
//   ex_stall       : hold IF/ID/EX while the op is not finished
//   md_result      : result, meaningful while result_valid
//   result_valid   : result available
module exu_muldiv_ctrl
    import exu_muldiv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = DATA_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_muldiv_en,
    input  logic [2:0]      ex_muldiv_op,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic            ex_flush,
    input  logic            ex_advance,
    output logic            ex_stall,
    output logic [XLEN-1:0] md_result,
    output logic            result_valid
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;          // negate product / quotient
    logic              neg_rem_q, neg_rem_d;  // negate remainder (dividend negative)
    logic [XLEN-1:0]   res_q, res_d;

    md_op_e            req_op;
    logic              req;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic              core_load, core_step;
    logic [XLEN-1:0]   core_hi_nxt, core_lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign req_op   = md_op_e'(ex_muldiv_op);
    assign req      = ex_valid & ex_muldiv_en;
    assign a_signed = (req_op == MD_MULH) | (req_op == MD_MULHSU) |
                      (req_op == MD_DIV)  | (req_op == MD_REM);
    assign b_signed = (req_op == MD_MULH) | (req_op == MD_DIV) | (req_op == MD_REM);
    assign a_neg    = a_signed & ex_rs1_data[XLEN-1];
    assign b_neg    = b_signed & ex_rs2_data[XLEN-1];
    assign mag_a    = a_neg ? -ex_rs1_data : ex_rs1_data;
    assign mag_b    = b_neg ? -ex_rs2_data : ex_rs2_data;

    assign div_zero = req_op[2] & (ex_rs2_data == '0);
    assign div_ovf  = ((req_op == MD_DIV) | (req_op == MD_REM)) &
                      (ex_rs1_data == INT_MIN) & (ex_rs2_data == '1);

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = ((req_op == MD_DIV) | (req_op == MD_DIVU)) ? '1 : ex_rs1_data;
        end else if (req_op == MD_DIV) begin
            special_res = INT_MIN;
        end
    end

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_q[2]),
        .a      (mag_a),
        .b      (mag_b),
        .hi_nxt (core_hi_nxt),
        .lo_nxt (core_lo_nxt)
    );

    // Fixup uses the core's next value so the result is written on the last step.
    always_comb begin
        prod = neg_q ? -{core_hi_nxt, core_lo_nxt} : {core_hi_nxt, core_lo_nxt};
        quo  = neg_q ? -core_lo_nxt : core_lo_nxt;
        rem  = neg_rem_q ? -core_hi_nxt : core_hi_nxt;
        case (op_q)
            MD_MUL:                        final_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_res = quo;
            default:                       final_res = rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        core_load = 1'b0;
        core_step = 1'b0;
        if (ex_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        op_d      = req_op;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        if (div_zero | div_ovf) begin
                            res_d   = special_res;
                            state_d = ST_DONE;
                        end else begin
                            core_load = 1'b1;
                            cnt_d     = CNT_W'(XLEN);
                            state_d   = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = final_res;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ex_advance) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
        end
    end

    assign result_valid = (state_q == ST_DONE);
    assign ex_stall     = req & (state_q != ST_DONE);
    assign md_result    = res_q;

endmodule
